// File: rtl/seq_writer_pkg.sv
// Shared types and helpers for the seq_writer burst producer.
// Holds the FSM encoding, the default data width and the modular increment.
package seq_writer_pkg;

   localparam int DEFAULT_WIDTH = 10;
   localparam int MAX_W         = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Callers zero-extend to MAX_W and truncate the result to their own width,
   // which drops the carry and gives modulo-2^W behaviour for any W <= MAX_W.
   function automatic logic [MAX_W-1:0] inc(input logic [MAX_W-1:0] a);
      return a + MAX_W'(1);
   endfunction

endpackage

// File: rtl/seq_writer_if.sv
// Valid/ready stream carrying the burst values from seq_writer to its consumer.
// A beat transfers on every rising edge where o_valid && i_ready; once o_valid
// is high, o_valid and o_data hold until that transfer, and o_valid never
// depends combinationally on i_ready.
interface seq_writer_if #(
   parameter int WIDTH = seq_writer_pkg::DEFAULT_WIDTH
) ();

   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_data;

   modport master (
      output o_valid,
      output o_data,
      input  i_ready
   );

   modport slave (
      input  o_valid,
      input  o_data,
      output i_ready
   );

endinterface

// File: rtl/seq_writer_beat_counter.sv
// Down-counter of beats left in the current burst.
// Loaded at start, decremented on each transfer, flags the final beat.
module seq_writer_beat_counter #(
   parameter int CNTW = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            load_i,
   input  logic [CNTW-1:0] load_val_i,
   input  logic            dec_i,
   output logic            is_last_o
);

   logic [CNTW-1:0] rem_q;
   logic [CNTW-1:0] rem_d;

   // The zero guard is defensive: a burst never enters RUN with zero beats.
   always_comb begin
      rem_d = rem_q;
      if (load_i) begin
         rem_d = load_val_i;
      end else if (dec_i && (rem_q != '0)) begin
         rem_d = rem_q - CNTW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign is_last_o = (rem_q == CNTW'(1));

endmodule

// File: rtl/seq_writer.sv
// Burst producer: emits i_count consecutive values starting at i_base on a
// valid/ready stream, then pulses o_done. All outputs come straight from flops.
module seq_writer
   import seq_writer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNTW  = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_base,
   input  logic [CNTW-1:0]  i_count,
   seq_writer_if.master     strm,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_wrap,
   output state_e           o_state_dbg
);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic             valid_q;
   logic             valid_d;
   logic             busy_q;
   logic             busy_d;
   logic             done_q;
   logic             done_d;
   logic             wrap_q;
   logic             wrap_d;

   logic             fire;
   logic             start_acc;
   logic             count_zero;
   logic             is_last;

   assign fire       = valid_q && strm.i_ready;
   assign start_acc  = (state_q == ST_IDLE) && i_start;
   assign count_zero = (i_count == '0);

   seq_writer_beat_counter #(
      .CNTW (CNTW)
   ) u_beat_counter (
      .clk_i      (i_clk),
      .rst_ni     (i_rst_n),
      .load_i     (start_acc && !count_zero),
      .load_val_i (i_count),
      .dec_i      (fire),
      .is_last_o  (is_last)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d = count_zero ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (fire && is_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Flag outputs are decoded from the next state so they land in flops
   // aligned with the state they describe.
   always_comb begin
      valid_d = (state_d == ST_RUN);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
      data_d  = data_q;
      wrap_d  = wrap_q;
      if (start_acc) begin
         wrap_d = 1'b0;
         if (!count_zero) begin
            data_d = i_base;
         end
      end else if (fire) begin
         data_d = WIDTH'(inc(MAX_W'(data_q)));
         if ((&data_q) && !is_last) begin
            wrap_d = 1'b1;
         end
      end
   end

   assign strm.o_valid = valid_q;
   assign strm.o_data  = data_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_wrap       = wrap_q;
   assign o_state_dbg  = state_q;

endmodule

// File: tb/tb_seq_writer.sv
// Directed bench for seq_writer at WIDTH=10 and WIDTH=20 with hand-computed
// expectations for each cycle of each burst.
module tb_seq_writer;
   import seq_writer_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start10;
   logic        start20;
   logic [9:0]  base10;
   logic [19:0] base20;
   logic [15:0] cnt10;
   logic [15:0] cnt20;
   logic        busy10, done10, wrap10;
   logic        busy20, done20, wrap20;
   state_e      st10, st20;

   seq_writer_if #(.WIDTH(10)) sif10 ();
   seq_writer_if #(.WIDTH(20)) sif20 ();

   seq_writer #(.WIDTH(10), .CNTW(16)) u10 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start10),
      .i_base      (base10),
      .i_count     (cnt10),
      .strm        (sif10),
      .o_busy      (busy10),
      .o_done      (done10),
      .o_wrap      (wrap10),
      .o_state_dbg (st10)
   );

   seq_writer #(.WIDTH(20), .CNTW(16)) u20 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start20),
      .i_base      (base20),
      .i_count     (cnt20),
      .strm        (sif20),
      .o_busy      (busy20),
      .o_done      (done20),
      .o_wrap      (wrap20),
      .o_state_dbg (st20)
   );

   int errors = 0;
   int checks = 0;
   int xfers;
   logic        rdy_pat [6];
   logic [19:0] exp_d   [6];
   logic        exp_v   [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      start10 = 1'b0; base10 = '0; cnt10 = '0; sif10.i_ready = 1'b0;
      start20 = 1'b0; base20 = '0; cnt20 = '0; sif20.i_ready = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid10", 32'(sif10.o_valid), 32'd0);
      check("rst_data10",  32'(sif10.o_data),  32'd0);
      check("rst_busy10",  32'(busy10), 32'd0);
      check("rst_done10",  32'(done10), 32'd0);
      check("rst_wrap10",  32'(wrap10), 32'd0);
      check("rst_state10", 32'(st10),   32'(ST_IDLE));
      check("rst_valid20", 32'(sif20.o_valid), 32'd0);
      check("rst_state20", 32'(st20),   32'(ST_IDLE));
      rst_n = 1'b1;
      tick();

      // Basic burst: base 5, count 4, ready high
      sif10.i_ready = 1'b1;
      start10 = 1'b1; base10 = 10'd5; cnt10 = 16'd4;
      tick();
      start10 = 1'b0;
      check("b1_valid0", 32'(sif10.o_valid), 32'd1);
      check("b1_data0",  32'(sif10.o_data),  32'd5);
      check("b1_busy",   32'(busy10), 32'd1);
      check("b1_state",  32'(st10), 32'(ST_RUN));
      tick();
      check("b1_data1",  32'(sif10.o_data),  32'd6);
      tick();
      check("b1_data2",  32'(sif10.o_data),  32'd7);
      tick();
      check("b1_data3",  32'(sif10.o_data),  32'd8);
      check("b1_valid3", 32'(sif10.o_valid), 32'd1);
      check("b1_done3",  32'(done10), 32'd0);
      tick();
      check("b1_done",   32'(done10), 32'd1);
      check("b1_vdone",  32'(sif10.o_valid), 32'd0);
      check("b1_dhold",  32'(sif10.o_data),  32'd9);
      check("b1_wrap",   32'(wrap10), 32'd0);
      tick();
      check("b1_done_off", 32'(done10), 32'd0);
      check("b1_idle_busy", 32'(busy10), 32'd0);

      // Wrapping burst: base 1022, count 3
      start10 = 1'b1; base10 = 10'd1022; cnt10 = 16'd3;
      tick();
      start10 = 1'b0;
      check("w_data0", 32'(sif10.o_data), 32'd1022);
      check("w_wrap0", 32'(wrap10), 32'd0);
      tick();
      check("w_data1", 32'(sif10.o_data), 32'd1023);
      check("w_wrap1", 32'(wrap10), 32'd0);
      tick();
      check("w_data2", 32'(sif10.o_data), 32'd0);
      check("w_wrap2", 32'(wrap10), 32'd1);
      tick();
      check("w_done",  32'(done10), 32'd1);
      check("w_dhold", 32'(sif10.o_data), 32'd1);
      check("w_wrap3", 32'(wrap10), 32'd1);
      tick();
      check("w_sticky", 32'(wrap10), 32'd1);
      check("w_idle",   32'(st10), 32'(ST_IDLE));

      // Zero-count start: no beats, done next cycle, clears sticky wrap
      start10 = 1'b1; base10 = 10'd33; cnt10 = 16'd0;
      tick();
      start10 = 1'b0;
      check("z_done",  32'(done10), 32'd1);
      check("z_valid", 32'(sif10.o_valid), 32'd0);
      check("z_busy",  32'(busy10), 32'd1);
      check("z_wrap",  32'(wrap10), 32'd0);
      tick();
      check("z_done_off", 32'(done10), 32'd0);
      check("z_valid2",   32'(sif10.o_valid), 32'd0);
      check("z_busy2",    32'(busy10), 32'd0);

      // Backpressure on the 20-bit instance
      rdy_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      exp_d   = '{20'd0, 20'd0, 20'd1, 20'd1, 20'd2, 20'd3};
      exp_v   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      xfers = 0;
      sif20.i_ready = 1'b0;
      start20 = 1'b1; base20 = 20'd0; cnt20 = 16'd3;
      tick();
      start20 = 1'b0;
      check("bp_data_acc",  32'(sif20.o_data),  32'd0);
      check("bp_valid_acc", 32'(sif20.o_valid), 32'd1);
      for (int i = 0; i < 6; i++) begin
         sif20.i_ready = rdy_pat[i];
         if (sif20.o_valid && sif20.i_ready) xfers++;
         tick();
         check($sformatf("bp_data%0d", i),  32'(sif20.o_data),  32'(exp_d[i]));
         check($sformatf("bp_valid%0d", i), 32'(sif20.o_valid), 32'(exp_v[i]));
      end
      sif20.i_ready = 1'b0;
      check("bp_xfers", 32'(xfers), 32'd3);
      check("bp_done",  32'(done20), 32'd1);
      tick();
      check("bp_done_off", 32'(done20), 32'd0);
      check("bp_busy_off", 32'(busy20), 32'd0);

      // Asynchronous reset during beat 2 of 5
      sif10.i_ready = 1'b1;
      start10 = 1'b1; base10 = 10'd50; cnt10 = 16'd5;
      tick();
      start10 = 1'b0;
      check("r_data0", 32'(sif10.o_data), 32'd50);
      tick();
      check("r_data1", 32'(sif10.o_data), 32'd51);
      #2 rst_n = 1'b0;
      #1;
      check("r_valid", 32'(sif10.o_valid), 32'd0);
      check("r_data",  32'(sif10.o_data),  32'd0);
      check("r_busy",  32'(busy10), 32'd0);
      check("r_done",  32'(done10), 32'd0);
      check("r_state", 32'(st10), 32'(ST_IDLE));
      tick();
      rst_n = 1'b1;
      tick();
      check("r_no_done", 32'(done10), 32'd0);
      check("r_idle",    32'(sif10.o_valid), 32'd0);
      start10 = 1'b1; base10 = 10'd7; cnt10 = 16'd2;
      tick();
      start10 = 1'b0;
      check("r2_data0", 32'(sif10.o_data), 32'd7);
      tick();
      check("r2_data1", 32'(sif10.o_data), 32'd8);
      tick();
      check("r2_done",  32'(done10), 32'd1);
      check("r2_dhold", 32'(sif10.o_data), 32'd9);
      tick();

      // Start requests while busy and during the done cycle are dropped
      start10 = 1'b1; base10 = 10'd200; cnt10 = 16'd3;
      tick();
      check("sb_data0", 32'(sif10.o_data), 32'd200);
      base10 = 10'd100; cnt10 = 16'd9;
      tick();
      start10 = 1'b0;
      check("sb_data1", 32'(sif10.o_data), 32'd201);
      tick();
      check("sb_data2", 32'(sif10.o_data), 32'd202);
      tick();
      check("sb_done",  32'(done10), 32'd1);
      check("sb_dhold", 32'(sif10.o_data), 32'd203);
      start10 = 1'b1;
      tick();
      start10 = 1'b0;
      check("sb_idle_valid", 32'(sif10.o_valid), 32'd0);
      check("sb_idle_busy",  32'(busy10), 32'd0);
      check("sb_idle_state", 32'(st10), 32'(ST_IDLE));
      tick();
      check("sb_no_relaunch", 32'(sif10.o_valid), 32'd0);
      check("sb_data_kept",   32'(sif10.o_data), 32'd203);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
